// File: rtl/mem_access_stage.sv
// ============================================================================
// Module   : mem_access_stage
// Brief    : Memory-access pipeline stage; issues loads/stores, registers results for writeback.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_stage #(
    parameter int XLEN      = 64,
    parameter int RF_ADDR_W = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    input  logic                 ex_valid_i,
    output logic                 ex_ready_o,
    input  logic [XLEN-1:0]      ex_alu_res_i,
    input  logic [XLEN-1:0]      ex_store_data_i,
    input  logic [XLEN-1:0]      ex_instr_imm_i,
    input  logic [XLEN-1:0]      ex_pc_val_i,
    input  logic                 ex_mem_rd_i,
    input  logic                 ex_mem_wr_i,
    input  logic [1:0]           ex_data_byte_en_i,
    input  logic                 ex_data_zero_extnd_i,
    input  logic [1:0]           ex_rf_wr_data_src_i,
    input  logic                 ex_rf_wr_en_i,
    input  logic [RF_ADDR_W-1:0] ex_rd_addr_i,
    input  logic                 flush_i,

    output logic                 dmem_req_valid_o,
    input  logic                 dmem_req_ready_i,
    output logic                 dmem_req_wr_o,
    output logic [XLEN-1:0]      dmem_req_addr_o,
    output logic [XLEN-1:0]      dmem_req_wdata_o,
    output logic [7:0]           dmem_req_wstrb_o,
    input  logic                 dmem_resp_valid_i,
    input  logic [XLEN-1:0]      dmem_resp_rdata_i,

    output logic                 wb_valid_o,
    input  logic                 wb_ready_i,
    output logic [XLEN-1:0]      wb_alu_res_o,
    output logic [XLEN-1:0]      wb_data_mem_rd_o,
    output logic [XLEN-1:0]      wb_instr_imm_o,
    output logic [XLEN-1:0]      wb_pc_val_o,
    output logic [1:0]           wb_rf_wr_data_src_o,
    output logic [1:0]           wb_data_byte_en_o,
    output logic                 wb_data_zero_extnd_o,
    output logic [2:0]           wb_data_mem_row_idx_o,
    output logic                 wb_rf_wr_en_o,
    output logic [RF_ADDR_W-1:0] wb_rd_addr_o,
    output logic                 wb_misalign_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [XLEN-1:0]        alu_res_q, alu_res_d;
    logic [XLEN-1:0]        store_data_q, store_data_d;
    logic [XLEN-1:0]        imm_q, imm_d;
    logic [XLEN-1:0]        pc_q, pc_d;
    logic [XLEN-1:0]        rdata_q, rdata_d;
    logic                   mem_rd_q, mem_rd_d;
    logic                   mem_wr_q, mem_wr_d;
    logic [1:0]             byte_en_q, byte_en_d;
    logic                   zext_q, zext_d;
    logic [1:0]             src_q, src_d;
    logic                   rf_wr_en_q, rf_wr_en_d;
    logic [RF_ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                   misalign_q, misalign_d;
    logic                   drop_q, drop_d;

    logic                   w_misalign;
    logic                   w_capture;
    logic                   w_req;
    logic                   w_store;
    logic [2:0]             w_off;
    logic [7:0]             w_strb_base;

    assign ex_ready_o = (state_q == S_IDLE) || ((state_q == S_HOLD) && wb_ready_i);
    assign w_capture  = ex_valid_i && ex_ready_o && !flush_i;

    // Alignment is judged on the incoming address so the branch is taken at capture.
    always_comb begin
        case (ex_data_byte_en_i)
            2'd0:    w_misalign = 1'b0;
            2'd1:    w_misalign = ex_alu_res_i[0];
            2'd2:    w_misalign = |ex_alu_res_i[1:0];
            default: w_misalign = |ex_alu_res_i[2:0];
        endcase
        w_misalign = w_misalign && (ex_mem_rd_i || ex_mem_wr_i);
    end

    always_comb begin
        state_d      = state_q;
        alu_res_d    = alu_res_q;
        store_data_d = store_data_q;
        imm_d        = imm_q;
        pc_d         = pc_q;
        rdata_d      = rdata_q;
        mem_rd_d     = mem_rd_q;
        mem_wr_d     = mem_wr_q;
        byte_en_d    = byte_en_q;
        zext_d       = zext_q;
        src_d        = src_q;
        rf_wr_en_d   = rf_wr_en_q;
        rd_addr_d    = rd_addr_q;
        misalign_d   = misalign_q;
        drop_d       = drop_q;

        case (state_q)
            S_IDLE: state_d = S_IDLE;
            S_REQ: begin
                // A flush coinciding with acceptance must still absorb the response.
                if (dmem_req_ready_i) begin
                    state_d = S_RESP;
                    drop_d  = flush_i;
                end else if (flush_i) begin
                    state_d = S_IDLE;
                end
            end
            S_RESP: begin
                if (dmem_resp_valid_i) begin
                    drop_d = 1'b0;
                    if (drop_q || flush_i) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_HOLD;
                        if (mem_rd_q) begin
                            rdata_d = dmem_resp_rdata_i;
                        end
                    end
                end else if (flush_i) begin
                    drop_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (flush_i || wb_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (w_capture) begin
            alu_res_d    = ex_alu_res_i;
            store_data_d = ex_store_data_i;
            imm_d        = ex_instr_imm_i;
            pc_d         = ex_pc_val_i;
            rdata_d      = '0;
            mem_rd_d     = ex_mem_rd_i;
            mem_wr_d     = ex_mem_wr_i;
            byte_en_d    = ex_data_byte_en_i;
            zext_d       = ex_data_zero_extnd_i;
            src_d        = ex_rf_wr_data_src_i;
            rf_wr_en_d   = ex_rf_wr_en_i && !w_misalign;
            rd_addr_d    = ex_rd_addr_i;
            misalign_d   = w_misalign;
            drop_d       = 1'b0;
            if (w_misalign || !(ex_mem_rd_i || ex_mem_wr_i)) begin
                state_d = S_HOLD;
            end else begin
                state_d = S_REQ;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            alu_res_q    <= '0;
            store_data_q <= '0;
            imm_q        <= '0;
            pc_q         <= '0;
            rdata_q      <= '0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            byte_en_q    <= '0;
            zext_q       <= 1'b0;
            src_q        <= '0;
            rf_wr_en_q   <= 1'b0;
            rd_addr_q    <= '0;
            misalign_q   <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            alu_res_q    <= alu_res_d;
            store_data_q <= store_data_d;
            imm_q        <= imm_d;
            pc_q         <= pc_d;
            rdata_q      <= rdata_d;
            mem_rd_q     <= mem_rd_d;
            mem_wr_q     <= mem_wr_d;
            byte_en_q    <= byte_en_d;
            zext_q       <= zext_d;
            src_q        <= src_d;
            rf_wr_en_q   <= rf_wr_en_d;
            rd_addr_q    <= rd_addr_d;
            misalign_q   <= misalign_d;
            drop_q       <= drop_d;
        end
    end

    assign w_req   = (state_q == S_REQ);
    assign w_store = w_req && mem_wr_q;
    assign w_off   = alu_res_q[2:0];

    always_comb begin
        case (byte_en_q)
            2'd0:    w_strb_base = 8'h01;
            2'd1:    w_strb_base = 8'h03;
            2'd2:    w_strb_base = 8'h0F;
            default: w_strb_base = 8'hFF;
        endcase
    end

    assign dmem_req_valid_o = w_req;
    assign dmem_req_wr_o    = w_store;
    assign dmem_req_addr_o  = w_req ? {alu_res_q[XLEN-1:3], 3'b000} : '0;
    assign dmem_req_wdata_o = w_store ? (store_data_q << {w_off, 3'b000}) : '0;
    assign dmem_req_wstrb_o = w_store ? (w_strb_base << w_off) : 8'h00;

    assign wb_valid_o            = (state_q == S_HOLD);
    assign wb_alu_res_o          = alu_res_q;
    assign wb_data_mem_rd_o      = rdata_q;
    assign wb_instr_imm_o        = imm_q;
    assign wb_pc_val_o           = pc_q;
    assign wb_rf_wr_data_src_o   = src_q;
    assign wb_data_byte_en_o     = byte_en_q;
    assign wb_data_zero_extnd_o  = zext_q;
    assign wb_data_mem_row_idx_o = alu_res_q[2:0];
    assign wb_rf_wr_en_o         = rf_wr_en_q;
    assign wb_rd_addr_o          = rd_addr_q;
    assign wb_misalign_o         = misalign_q;

endmodule

`default_nettype wire
